// File: rtl/multi_lane_fetch_queue_pkg.sv
// Shared constants and entry layout for the multi-lane fetched-op queue.
// One packed entry is FOQ_ENTRY_W bits; the field offsets below locate each field within it.
package multi_lane_fetch_queue_pkg;

    localparam int FOQ_ENTRY_W   = 88;
    localparam int FOQ_DEPTH_DEF = 16;
    localparam int FOQ_STEP_W    = 2;

    localparam int FOQ_OP_LSB      = 0;
    localparam int FOQ_OP_W        = 5;
    localparam int FOQ_RD_LSB      = 5;
    localparam int FOQ_RS1_LSB     = 10;
    localparam int FOQ_RS2_LSB     = 15;
    localparam int FOQ_REG_W       = 5;
    localparam int FOQ_IMM_LSB     = 20;
    localparam int FOQ_IMM_W       = 32;
    localparam int FOQ_BRANCH_BIT  = 52;
    localparam int FOQ_LS_BIT      = 53;
    localparam int FOQ_USE_IMM_BIT = 54;
    localparam int FOQ_JALR_BIT    = 55;
    localparam int FOQ_ADDR_LSB    = 56;
    localparam int FOQ_ADDR_W      = 32;

    // The first member is the most significant field, so the layout matches the offsets above.
    typedef struct packed {
        logic [FOQ_ADDR_W-1:0] addr;
        logic                  jalr;
        logic                  use_imm;
        logic                  ls;
        logic                  branch;
        logic [FOQ_IMM_W-1:0]  imm;
        logic [FOQ_REG_W-1:0]  rs2;
        logic [FOQ_REG_W-1:0]  rs1;
        logic [FOQ_REG_W-1:0]  rd;
        logic [FOQ_OP_W-1:0]   op;
    } foq_entry_t;

endpackage

// File: rtl/multi_lane_fetch_queue_ptr_adv.sv
// fq_ptr_adv: circular-buffer pointer with async active-low reset, sync clear and advance by 0..2.
// Wrap is the natural modulo of the pointer width.
module fq_ptr_adv
    import multi_lane_fetch_queue_pkg::*;
#(
    parameter int PTR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [FOQ_STEP_W-1:0] step,
    output logic [PTR_W-1:0]      ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (enable) begin
            ptr <= ptr + PTR_W'(step);
        end
    end

endmodule

// File: rtl/multi_lane_fetch_queue.sv
// Multi-lane in-order fetched-op queue: up to PUSH_LANES enqueues and POP_LANES dequeues per cycle.
// Optional occupancy/stall statistics are compiled in with MULTI_LANE_FETCH_QUEUE_STATS_EN.
module multi_lane_fetch_queue
    import multi_lane_fetch_queue_pkg::*;
#(
    parameter int DATA_W     = FOQ_ENTRY_W,
    parameter int DEPTH      = FOQ_DEPTH_DEF,
    parameter int PUSH_LANES = 2,
    parameter int POP_LANES  = 2,
    parameter int AFULL_TH   = DEPTH - 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic [PUSH_LANES-1:0]        push_valid,
    input  logic [PUSH_LANES*DATA_W-1:0] push_data,
    output logic [PUSH_LANES-1:0]        push_ready,
    output logic [POP_LANES-1:0]         pop_valid,
    output logic [POP_LANES*DATA_W-1:0]  pop_data,
    input  logic [POP_LANES-1:0]         pop_take,
    output logic [$clog2(DEPTH):0]       count_out,
    output logic                         afull_out,
    output logic                         full_out
`ifdef MULTI_LANE_FETCH_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]       hwm_out,
    output logic [31:0]                  stall_cnt_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]      front;
    logic [PTR_W-1:0]      rear;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [CNT_W-1:0]      free;
    logic [PUSH_LANES-1:0] push_acc;
    logic [POP_LANES-1:0]  pop_acc;
    logic [FOQ_STEP_W-1:0] n_push;
    logic [FOQ_STEP_W-1:0] n_pop;
    logic                  push_run;
    logic                  pop_run;
    logic                  advance;

    // Handshakes come from the registered count only, so a same-cycle pop never frees push space.
    assign free = CNT_W'(DEPTH) - count;

    always_comb begin
        push_ready = '0;
        for (int k = 0; k < PUSH_LANES; k++) begin
            push_ready[k] = (free > CNT_W'(k));
        end
    end

    always_comb begin
        pop_valid = '0;
        for (int k = 0; k < POP_LANES; k++) begin
            pop_valid[k] = (count > CNT_W'(k));
        end
    end

    // Only a leading run of accepted lanes counts; a lane-1 request without lane 0 is dropped.
    always_comb begin
        push_acc = '0;
        n_push   = '0;
        push_run = 1'b1;
        for (int k = 0; k < PUSH_LANES; k++) begin
            push_run    = push_run & push_valid[k] & push_ready[k];
            push_acc[k] = push_run;
            if (push_run) begin
                n_push = n_push + FOQ_STEP_W'(1);
            end
        end
    end

    always_comb begin
        pop_acc = '0;
        n_pop   = '0;
        pop_run = 1'b1;
        for (int k = 0; k < POP_LANES; k++) begin
            pop_run    = pop_run & pop_take[k] & pop_valid[k];
            pop_acc[k] = pop_run;
            if (pop_run) begin
                n_pop = n_pop + FOQ_STEP_W'(1);
            end
        end
    end

    assign advance   = rdy_in & ~flush_in;
    assign count_nxt = count + CNT_W'(n_push) - CNT_W'(n_pop);

    fq_ptr_adv #(.PTR_W(PTR_W)) u_front (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .clear  (flush_in),
        .enable (rdy_in),
        .step   (n_pop),
        .ptr    (front)
    );

    fq_ptr_adv #(.PTR_W(PTR_W)) u_rear (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .clear  (flush_in),
        .enable (rdy_in),
        .step   (n_push),
        .ptr    (rear)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (flush_in) begin
            count <= '0;
        end else if (rdy_in) begin
            count <= count_nxt;
        end
    end

    // Storage is never cleared; entry validity lives entirely in count.
    always_ff @(posedge clk_in) begin
        if (rst_in && advance) begin
            for (int k = 0; k < PUSH_LANES; k++) begin
                if (push_acc[k]) begin
                    mem[rear + PTR_W'(k)] <= push_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        pop_data = '0;
        for (int k = 0; k < POP_LANES; k++) begin
            if (pop_valid[k]) begin
                pop_data[k*DATA_W +: DATA_W] = mem[front + PTR_W'(k)];
            end
        end
    end

    assign count_out = count;
    assign full_out  = (count == CNT_W'(DEPTH));
    assign afull_out = (count >= CNT_W'(AFULL_TH));

`ifdef MULTI_LANE_FETCH_QUEUE_STATS_EN
    logic [CNT_W-1:0] hwm;
    logic [31:0]      stall_cnt;

    // Both statistics survive a flush; only reset clears them.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hwm       <= '0;
            stall_cnt <= '0;
        end else if (rdy_in) begin
            if (!flush_in && (count_nxt > hwm)) begin
                hwm <= count_nxt;
            end
            if (push_valid[0] && !push_ready[0] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign hwm_out       = hwm;
    assign stall_cnt_out = stall_cnt;
`endif

endmodule

// File: tb/tb_multi_lane_fetch_queue.sv
// Scoreboard bench for multi_lane_fetch_queue: stimulus queues expected pop data, a negedge monitor checks it.
// Also exercises hwm_out/stall_cnt_out when MULTI_LANE_FETCH_QUEUE_STATS_EN is defined.
module tb_multi_lane_fetch_queue;

    localparam int DATA_W = 88;
    localparam int DEPTH  = 16;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                rdy_in;
    logic                flush_in;
    logic [1:0]          push_valid;
    logic [2*DATA_W-1:0] push_data;
    logic [1:0]          push_ready;
    logic [1:0]          pop_valid;
    logic [2*DATA_W-1:0] pop_data;
    logic [1:0]          pop_take;
    logic [4:0]          count_out;
    logic                afull_out;
    logic                full_out;
`ifdef MULTI_LANE_FETCH_QUEUE_STATS_EN
    logic [4:0]          hwm_out;
    logic [31:0]         stall_cnt_out;
`endif

    multi_lane_fetch_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PUSH_LANES(2), .POP_LANES(2), .AFULL_TH(DEPTH - 2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .push_valid    (push_valid),
        .push_data     (push_data),
        .push_ready    (push_ready),
        .pop_valid     (pop_valid),
        .pop_data      (pop_data),
        .pop_take      (pop_take),
        .count_out     (count_out),
        .afull_out     (afull_out),
        .full_out      (full_out)
`ifdef MULTI_LANE_FETCH_QUEUE_STATS_EN
        ,
        .hwm_out       (hwm_out),
        .stall_cnt_out (stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    logic [DATA_W-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] item(input int i);
        return {24'hA5C3E1, 32'(i), 32'(i * 3 + 1)};
    endfunction

    task automatic drive(input logic [1:0] pv, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [1:0] pt);
        push_valid = pv;
        push_data  = {d1, d0};
        pop_take   = pt;
        @(posedge clk_in);
        #1;
        push_valid = 2'b00;
        pop_take   = 2'b00;
    endtask

    // Monitor: every accepted pop must deliver the oldest outstanding expected entry.
    always @(negedge clk_in) begin
        logic [DATA_W-1:0] e;
        if (rst_in === 1'b1 && rdy_in === 1'b1 && flush_in === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                if (pop_take[0] && pop_valid[0] && (k == 0 || (pop_take[1] && pop_valid[1]))) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL pop_unexpected: lane %0d data %0h with empty scoreboard", k,
                                 pop_data[k*DATA_W +: DATA_W]);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("pop_data_l%0d", k), 128'(pop_data[k*DATA_W +: DATA_W]), 128'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        flush_in   = 1'b0;
        push_valid = 2'b00;
        push_data  = '0;
        pop_take   = 2'b00;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        chk("rst_pop_valid", 128'(pop_valid), 128'(2'b00));
        chk("rst_pop_data_zero", 128'(pop_data == '0), 128'(1));
        chk("rst_push_ready", 128'(push_ready), 128'(2'b11));
        chk("rst_count", 128'(count_out), 128'(0));
        chk("rst_afull", 128'(afull_out), 128'(0));
        chk("rst_full", 128'(full_out), 128'(0));
`ifdef MULTI_LANE_FETCH_QUEUE_STATS_EN
        chk("rst_hwm", 128'(hwm_out), 128'(0));
        chk("rst_stall", 128'(stall_cnt_out), 128'(0));
`endif

        // Single lane-0 push is visible the next cycle.
        exp_q.push_back(item(1));
        drive(2'b01, item(1), '0, 2'b00);
        chk("one_pop_valid", 128'(pop_valid), 128'(2'b01));
        chk("one_pop_data", 128'(pop_data[DATA_W-1:0]), 128'(item(1)));
        chk("one_count", 128'(count_out), 128'(1));
        drive(2'b00, '0, '0, 2'b01);
        chk("one_drained", 128'(count_out), 128'(0));

        // Lane-1 request without lane 0 is ignored.
        drive(2'b10, '0, item(2), 2'b00);
        chk("lane1_only_count", 128'(count_out), 128'(0));

        // Dual-push to full, watching the almost-full threshold on the way.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(item(100 + 2 * i));
            exp_q.push_back(item(101 + 2 * i));
            drive(2'b11, item(100 + 2 * i), item(101 + 2 * i), 2'b00);
            chk("fill_count", 128'(count_out), 128'(2 * (i + 1)));
            chk("fill_afull", 128'(afull_out), 128'(2 * (i + 1) >= 14));
        end
        chk("full_flag", 128'(full_out), 128'(1));
        chk("full_push_ready", 128'(push_ready), 128'(2'b00));
        drive(2'b11, item(900), item(901), 2'b00);
        chk("ninth_dropped", 128'(count_out), 128'(16));
        // Full with push and pop together: pop wins, push is refused.
        drive(2'b01, item(902), '0, 2'b01);
        chk("full_push_pop", 128'(count_out), 128'(15));
        repeat (8) drive(2'b00, '0, '0, 2'b11);
        chk("drain_count", 128'(count_out), 128'(0));
        chk("drain_sb_empty", 128'(exp_q.size()), 128'(0));

        // Fill to 15, then a dual push lands only lane 0.
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(item(300 + 2 * i));
            exp_q.push_back(item(301 + 2 * i));
            drive(2'b11, item(300 + 2 * i), item(301 + 2 * i), 2'b00);
        end
        exp_q.push_back(item(314));
        drive(2'b01, item(314), '0, 2'b00);
        chk("at15_push_ready", 128'(push_ready), 128'(2'b01));
        exp_q.push_back(item(315));
        drive(2'b11, item(315), item(316), 2'b00);
        chk("at15_count", 128'(count_out), 128'(16));
        chk("at15_full", 128'(full_out), 128'(1));
        repeat (8) drive(2'b00, '0, '0, 2'b11);
        chk("at15_drain", 128'(count_out), 128'(0));

        // Wrap: one in, one out per cycle; the first pop is against an empty queue.
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(item(200 + i));
            drive(2'b01, item(200 + i), '0, 2'b01);
            chk("wrap_count", 128'(count_out), 128'(1));
        end
        drive(2'b00, '0, '0, 2'b01);
        chk("wrap_empty", 128'(count_out), 128'(0));
        chk("wrap_ptr_eq", 128'(dut.front), 128'(dut.rear));

        // Flush at count 5 together with a dual push and a pop.
        exp_q.push_back(item(400));
        exp_q.push_back(item(401));
        drive(2'b11, item(400), item(401), 2'b00);
        exp_q.push_back(item(402));
        exp_q.push_back(item(403));
        drive(2'b11, item(402), item(403), 2'b00);
        exp_q.push_back(item(404));
        drive(2'b01, item(404), '0, 2'b00);
        chk("pre_flush_count", 128'(count_out), 128'(5));
        flush_in = 1'b1;
        drive(2'b11, item(410), item(411), 2'b01);
        flush_in = 1'b0;
        exp_q.delete();
        chk("flush_count", 128'(count_out), 128'(0));
        chk("flush_pop_valid", 128'(pop_valid), 128'(2'b00));
        chk("flush_pop_data_zero", 128'(pop_data == '0), 128'(1));
`ifdef MULTI_LANE_FETCH_QUEUE_STATS_EN
        chk("hwm_after_flush", 128'(hwm_out), 128'(16));
        chk("stall_count", 128'(stall_cnt_out), 128'(2));
`endif

        // Global enable low freezes everything.
        exp_q.push_back(item(500));
        exp_q.push_back(item(501));
        drive(2'b11, item(500), item(501), 2'b00);
        exp_q.push_back(item(502));
        drive(2'b01, item(502), '0, 2'b00);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, item(510), item(511), 2'b11);
            chk("hold_count", 128'(count_out), 128'(3));
            chk("hold_pop_valid", 128'(pop_valid), 128'(2'b11));
            chk("hold_pop_data", 128'(pop_data[DATA_W-1:0]), 128'(item(500)));
        end
        rdy_in = 1'b1;
        repeat (2) drive(2'b00, '0, '0, 2'b11);
        chk("hold_drain", 128'(count_out), 128'(0));
        chk("hold_sb_empty", 128'(exp_q.size()), 128'(0));

        // Reset mid-cycle takes effect without a clock edge.
        drive(2'b11, item(600), item(601), 2'b00);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_count", 128'(count_out), 128'(0));
        chk("async_rst_pop_valid", 128'(pop_valid), 128'(2'b00));
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        exp_q.push_back(item(700));
        drive(2'b01, item(700), '0, 2'b00);
        chk("post_rst_count", 128'(count_out), 128'(1));
        drive(2'b00, '0, '0, 2'b01);
        chk("post_rst_sb_empty", 128'(exp_q.size()), 128'(0));

        repeat (2) @(posedge clk_in);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_lane_fetch_queue.md
# multi_lane_fetch_queue

Parametrised, multi-lane successor to the single-lane fetched-op queue, sitting between instruction fetch/decode and the issue stage. Each cycle it accepts up to `PUSH_LANES` decoded ops and presents up to `POP_LANES` ops in program order. It exposes occupancy and per-lane ready/valid handshakes, and supports a full clear on branch mispredict.

## Interface
- `DATA_W`, 88, width of one packed entry (op, rd, rs1, rs2, imm, flags, addr).
- `DEPTH`, 16, entry count; power of two, at least 4.
- `PUSH_LANES`, 2, enqueue lanes; 1 or 2.
- `POP_LANES`, 2, dequeue lanes; 1 or 2.
- `AFULL_TH`, DEPTH-2, `afull_out` asserts when count is at least this value.

Ports:
- `clk_in`, in, 1, clock.
- `rst_in`, in, 1, asynchronous, active-low reset.
- `rdy_in`, in, 1, global enable; when low, all state is frozen.
- `flush_in`, in, 1, synchronous clear (mispredict).
- `push_valid`, in, PUSH_LANES, per-lane enqueue request; lane 1 is valid only when lane 0 is also valid.
- `push_data`, in, PUSH_LANES*DATA_W, lane k occupies bits [k*DATA_W +: DATA_W].
- `push_ready`, out, PUSH_LANES, lane k can accept: `free > k`.
- `pop_valid`, out, POP_LANES, lane k holds an entry: `count > k`.
- `pop_data`, out, POP_LANES*DATA_W, entry at front+k; all zero when the lane is not valid.
- `pop_take`, in, POP_LANES, consumer takes lane k; lane 1 counts only with lane 0.
- `count_out`, out, clog2(DEPTH)+1, occupancy.
- `afull_out`, out, 1, almost-full.
- `full_out`, out, 1, `count == DEPTH`.

## Operation
- Circular buffer with `front` and `rear` pointers, each clog2(DEPTH) bits. Wrap is the natural modulo 2^n. A separate `count` register removes full/empty ambiguity.
- Accepted pushes: n_push = number of leading lanes with `push_valid && push_ready`. A lane-1 request without lane 0 is ignored and counts as n_push = 0 for that lane.
- Accepted pops: n_pop = number of leading lanes with `pop_take && pop_valid`.
- Entries are written at `rear`, `rear+1` in lane order. `rear += n_push` and `front += n_pop`.
- `count += n_push - n_pop`. The result is never negative and never above DEPTH.
- `push_ready` comes from registered `free = DEPTH - count` at the start of the cycle. Same-cycle pops do not create push space, so there is no combinational pop-to-push path.
- Priority, highest first:
  - reset
  - flush: pointers and count go to 0; same-cycle push and pop are discarded.
  - `!rdy_in`: no change; pushes and pops are ignored, and outputs reflect held state.
  - normal push/pop
- Storage contents are not cleared on reset or flush. Validity is derived from `count` only.

## Timing
- Reset values: `front`, `rear`, `count` = 0. `pop_valid` = 0, `pop_data` = 0, `push_ready` = all ones, `count_out` = 0, `afull_out` = 0, `full_out` = 0. Stats registers (if compiled in) = 0.
- Push-to-pop latency is 1 cycle: data pushed at edge N is visible on `pop_data` after edge N.
- `pop_valid`, `pop_data`, `push_ready`, `count_out`, `afull_out` and `full_out` are decoded from registers only (read mux from `front`).
- Simultaneous push and pop when full: the pop is accepted and the push is rejected (`push_ready` = 0).
- Simultaneous push and pop when empty: the pop is impossible (`pop_valid` = 0) and the push is accepted.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- `MULTI_LANE_FETCH_QUEUE_STATS_EN`
  - Defined: adds output `hwm_out` (clog2(DEPTH)+1), the maximum `count` since reset. Also adds `stall_cnt_out` (32 bits, saturating), incremented in each rdy cycle where `push_valid[0]` is high and `push_ready[0]` is low. Flush does not clear either register.
  - Undefined: neither port nor register exists; behaviour is otherwise identical.

## Structure
- Shared package / `macros.v`:
  - `FOQ_ENTRY_W` (88)
  - `FOQ_DEPTH_DEF`
  - field offset constants for op, rd, rs1, rs2, imm, branch, ls, use_imm, jalr, addr
- Sub-module `fq_ptr_adv`: pointer register with asynchronous active-low reset, synchronous clear, and advance by 0..2. Instanced twice, for `front` and `rear`.

## Test plan
- Reset, then push A at lane 0 only → next cycle `pop_valid` = 01, `pop_data` lane 0 = A, `count_out` = 1.
- DEPTH = 16: dual-push 8 cycles with no pops → `full_out` = 1, `push_ready` = 00, `count_out` = 16. A ninth push is dropped, and a later drain returns the 16 entries in order.
- Fill to 15, then push two lanes → only lane 0 is accepted (`push_ready` = 01), `count_out` = 16.
- Wrap: push/pop 1 per cycle 40 times → data order is preserved and `front == rear` whenever `count_out` = 0.
- `flush_in` together with a dual push and a pop at count 5 → next cycle `count_out` = 0, `pop_valid` = 00, `pop_data` = 0.
- `rdy_in` = 0 for 3 cycles with pushes and takes asserted → `count_out` and outputs are unchanged. With STATS_EN, `hwm_out` holds its peak value across a flush.
